// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader writing instruction memory behind a CPU hold
module program_loader #(
    parameter int           WORD_SIZE  = 32,
    parameter int           ADDR_WIDTH = 8,
    parameter logic [7:0]   SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_COUNT, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              n_q, n_d;
    logic [WORD_SIZE-1:0]    asm_q, asm_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    done_q, error_q;
    logic                    accept, restart, last_word;

    assign accept    = byte_valid & byte_ready;
    assign restart   = start & (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    // A count byte of 0 makes n_q - 1 wrap to 255, giving 256 words.
    assign last_word = (8'(word_idx_q) == (n_q - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_HDR;
            ST_HDR:   if (accept && byte_data == SYNC_BYTE) state_d = ST_COUNT;
            ST_COUNT: if (accept) state_d = ST_DATA;
            ST_DATA:  if (accept && byte_idx_q == 2'd3) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_CHECK : ST_DATA;
            ST_CHECK: if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = state_q inside {ST_HDR, ST_COUNT, ST_DATA, ST_CHECK};
        mem_we     = (state_q == ST_WRITE);
        cpu_hold   = (state_q != ST_DONE);
    end

    always_comb begin
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        n_d         = n_q;
        asm_d       = asm_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (restart) begin
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            asm_d      = '0;
        end
        case (state_q)
            ST_COUNT: if (accept) n_d = byte_data;
            ST_DATA: if (accept) begin
                csum_d = csum_q ^ byte_data;
                asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                byte_idx_d = byte_idx_q + 2'd1;
                // Capture the full word on the fourth byte so WRITE presents it immediately.
                if (byte_idx_q == 2'd3) begin
                    mem_addr_d  = word_idx_q;
                    mem_wdata_d = asm_d;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                byte_idx_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            n_q         <= '0;
            asm_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            n_q         <= n_d;
            asm_q       <= asm_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERR);
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
